exc_ctrl: RTL
=============

// Module: exc_ctrl
// PURPOSE
//  MEM-stage exception controller. Sits directly upstream of the CP0 register file.
//  - Collects per-instruction exception flags and the pending hardware/timer interrupt.
//  - Picks one exception by priority and drives CP0's excepttype/current_inst_addr/
//    is_in_delayslot/bad_addr inputs.
//  - Issues the pipeline flush and redirect PC (vector, or EPC for ERET).
// PARAMETERS
//  EXC_VECTOR    32'hBFC00380  redirect target for every exception except ERET
//  FLUSH_CYCLES  1             cycles flush_o stays high per commit; legal range 1..7
// PORTS
//  clk             in   1   system clock, rising edge
//  rst             in   1   reset, asynchronous, active-high
//  stall_i         in   1   MEM stage stalled; its instruction does not commit
//  valid_i         in   1   MEM stage holds a real instruction (not a bubble)
//  pc_i            in   32  PC of the MEM-stage instruction
//  is_in_delayslot_i in 1   MEM-stage instruction is in a branch delay slot
//  mem_addr_i      in   32  data address of the MEM-stage load/store
//  adel_if_i       in   1   fetch address error (misaligned PC)
//  ri_i            in   1   reserved instruction
//  ov_i            in   1   arithmetic overflow
//  syscall_i       in   1   SYSCALL
//  break_i         in   1   BREAK
//  adel_mem_i      in   1   load address error
//  ades_i          in   1   store address error
//  eret_i          in   1   ERET
//  status_i        in   32  CP0 Status, already forwarded
//  cause_i         in   32  CP0 Cause, already forwarded
//  epc_i           in   32  CP0 EPC, already forwarded
//  excepttype_o    out  32  code to CP0; 0 = none
//  current_inst_addr_o out 32  = pc_i
//  is_in_delayslot_o out 1   = is_in_delayslot_i
//  bad_addr_o      out  32  faulting virtual address
//  flush_o         out  1   flush IF..MEM and redirect fetch
//  newpc_o         out  32  redirect target, valid while flush_o=1
// BEHAVIOUR
//  Reset:
//   - Asynchronous; returns FSM to IDLE and clears int_pend.
//   - While rst=1 all outputs are 0.
//   - Reset in the middle of FLUSH aborts it; flush_o falls with rst.
//  Interrupt request:
//   - int_req = |(cause_i[15:8] & status_i[15:8]) & status_i[0] & ~status_i[1].
//   - int_pend <= (int_pend | int_req) & status_i[0] & ~status_i[1], every cycle.
//  Commit:
//   - commit = valid_i & ~stall_i & (state==IDLE).
//   - Bubbles and stalled cycles never take an exception; the interrupt stays pending.
//  Priority, highest first (codes per defines.vh):
//   - INT(0x01) > AdEL-fetch(0x04) > RI(0x0a) > Ov(0x0c) > Sys(0x08) > Bp(0x09)
//     > AdEL-mem(0x04) > AdES(0x05) > ERET(0x0e).
//   - INT condition is int_req | int_pend.
//  bad_addr_o:
//   - pc_i for AdEL-fetch; mem_addr_i for AdEL-mem and AdES; otherwise 0.
//  Commit cycle T, combinational, code != 0:
//   - excepttype_o = code, valid only while commit=1; CP0 samples it on the falling edge of T.
//   - flush_o = 1.
//   - newpc_o = epc_i for ERET, else EXC_VECTOR.
//  FSM:
//   - IDLE -> FLUSH on commit with code != 0; newpc registered into hold_pc and cnt = FLUSH_CYCLES-1.
//     If FLUSH_CYCLES=1, stay in IDLE.
//   - FLUSH: flush_o=1, newpc_o=hold_pc, excepttype_o=0; cnt decrements each cycle.
//     Inputs are ignored: the instruction is being squashed.
//   - FLUSH -> IDLE when cnt==1.
//  Width: cnt is 3 bits. No arithmetic on PCs; the EPC delay-slot adjust happens in CP0.
//  Simultaneous events:
//   - ERET with any other flag: the other flag wins.
//   - Interrupt arriving during FLUSH: latched into int_pend, taken on the first commit after IDLE.
// STRUCTURE
//  - Exception code constants and EXC_VECTOR default go in defines.vh beside the CP0_REG_* constants.
//  - One sub-module, exc_prio_enc: combinational flags -> {code, bad_addr_sel}.
//  - FSM, int_pend and hold_pc stay in exc_ctrl.
// TESTING
//  1. Reset mid-flush: FLUSH_CYCLES=3, ov_i commit, rst pulse in cycle 2
//     -> flush_o=0 immediately; next commit with no flags gives excepttype_o=0.
//  2. Interrupt: status=0x0000_0401, cause[10]=1, valid_i=1, pc=0x80001000
//     -> excepttype_o=0x01, flush_o=1, newpc_o=0xBFC00380.
//  3. Fetch vs data error: adel_if_i=1, adel_mem_i=1, pc=0x80000002, addr=0x10
//     -> code 0x04, bad_addr_o=0x80000002.
//  4. Stall/bubble: int_req 1 cycle with stall_i=1, then valid_i=0, then commit
//     -> code 0x01 only on the commit cycle.
//  5. ERET: eret_i=1, epc_i=0x8000_0040 -> code 0x0e, newpc_o=0x8000_0040;
//     with syscall_i=1 also set -> code 0x08.
//  6. FLUSH_CYCLES=3: syscall commit -> flush_o high 3 cycles, newpc steady;
//     break_i during cycles 2-3 is ignored.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared exception codes, redirect vector and types for the MEM-stage exception controller.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    typedef enum logic [1:0] {
        BAD_NONE,
        BAD_PC,
        BAD_MEM
    } bad_sel_e;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_e;

    typedef struct packed {
        logic [31:0] code;
        bad_sel_e    bad_sel;
    } exc_sel_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage/CP0 bundle seen by the exception controller (slave) and the pipeline side (master).
interface exc_ctrl_if;
    logic        stall_i;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] mem_addr_i;
    logic        adel_if_i;
    logic        ri_i;
    logic        ov_i;
    logic        syscall_i;
    logic        break_i;
    logic        adel_mem_i;
    logic        ades_i;
    logic        eret_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] newpc_o;

    modport master (
        output stall_i, valid_i, pc_i, is_in_delayslot_i, mem_addr_i,
               adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_mem_i, ades_i, eret_i,
               status_i, cause_i, epc_i,
        input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
               flush_o, newpc_o
    );

    modport slave (
        input  stall_i, valid_i, pc_i, is_in_delayslot_i, mem_addr_i,
               adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_mem_i, ades_i, eret_i,
               status_i, cause_i, epc_i,
        output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
               flush_o, newpc_o
    );
endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// Fixed-priority exception encoder: flags -> {code, bad address source}.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic     int_i,
    input  logic     adel_if_i,
    input  logic     ri_i,
    input  logic     ov_i,
    input  logic     syscall_i,
    input  logic     break_i,
    input  logic     adel_mem_i,
    input  logic     ades_i,
    input  logic     eret_i,
    output exc_sel_t sel_o
);

    always_comb begin
        sel_o = '{code: EXC_NONE, bad_sel: BAD_NONE};
        if (int_i)           sel_o = '{code: EXC_INT,  bad_sel: BAD_NONE};
        else if (adel_if_i)  sel_o = '{code: EXC_ADEL, bad_sel: BAD_PC};
        else if (ri_i)       sel_o = '{code: EXC_RI,   bad_sel: BAD_NONE};
        else if (ov_i)       sel_o = '{code: EXC_OV,   bad_sel: BAD_NONE};
        else if (syscall_i)  sel_o = '{code: EXC_SYS,  bad_sel: BAD_NONE};
        else if (break_i)    sel_o = '{code: EXC_BP,   bad_sel: BAD_NONE};
        else if (adel_mem_i) sel_o = '{code: EXC_ADEL, bad_sel: BAD_MEM};
        else if (ades_i)     sel_o = '{code: EXC_ADES, bad_sel: BAD_MEM};
        else if (eret_i)     sel_o = '{code: EXC_ERET, bad_sel: BAD_NONE};
    end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: picks one exception, drives CP0 inputs, flushes and redirects fetch.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input logic       clk,
    input logic       rst,
    exc_ctrl_if.slave bus
);

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        int_pend_q, int_pend_d;

    logic        int_en;
    logic        int_req;
    logic        commit;
    logic        take;
    logic [31:0] exc_pc;
    exc_sel_t    sel;

    logic unused_bits;
    assign unused_bits = ^{bus.cause_i[31:16], bus.cause_i[7:0],
                           bus.status_i[31:16], bus.status_i[7:2]};

    assign int_en  = bus.status_i[0] & ~bus.status_i[1];
    assign int_req = (|(bus.cause_i[15:8] & bus.status_i[15:8])) & int_en;
    assign commit  = bus.valid_i & ~bus.stall_i & (state_q == ST_IDLE);

    exc_prio_enc u_prio (
        .int_i      (int_req | int_pend_q),
        .adel_if_i  (bus.adel_if_i),
        .ri_i       (bus.ri_i),
        .ov_i       (bus.ov_i),
        .syscall_i  (bus.syscall_i),
        .break_i    (bus.break_i),
        .adel_mem_i (bus.adel_mem_i),
        .ades_i     (bus.ades_i),
        .eret_i     (bus.eret_i),
        .sel_o      (sel)
    );

    assign take   = commit & (sel.code != EXC_NONE);
    assign exc_pc = (sel.code == EXC_ERET) ? bus.epc_i : EXC_VECTOR;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_pc_d  = hold_pc_q;
        int_pend_d = (int_pend_q | int_req) & int_en;
        unique case (state_q)
            ST_IDLE: begin
                // A single-cycle flush is fully covered by the combinational commit cycle.
                if (take && FLUSH_CYCLES > 1) begin
                    state_d   = ST_FLUSH;
                    cnt_d     = CNT_INIT;
                    hold_pc_d = exc_pc;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hold_pc_q  <= '0;
            int_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_pc_q  <= hold_pc_d;
            int_pend_q <= int_pend_d;
        end
    end

    always_comb begin
        bus.excepttype_o        = '0;
        bus.current_inst_addr_o = '0;
        bus.is_in_delayslot_o   = 1'b0;
        bus.bad_addr_o          = '0;
        bus.flush_o             = 1'b0;
        bus.newpc_o             = '0;
        if (!rst) begin
            bus.current_inst_addr_o = bus.pc_i;
            bus.is_in_delayslot_o   = bus.is_in_delayslot_i;
            if (state_q == ST_FLUSH) begin
                bus.flush_o = 1'b1;
                bus.newpc_o = hold_pc_q;
            end else if (take) begin
                bus.excepttype_o = sel.code;
                bus.flush_o      = 1'b1;
                bus.newpc_o      = exc_pc;
                unique case (sel.bad_sel)
                    BAD_PC:  bus.bad_addr_o = bus.pc_i;
                    BAD_MEM: bus.bad_addr_o = bus.mem_addr_i;
                    default: bus.bad_addr_o = '0;
                endcase
            end
        end
    end

endmodule
